// File: rtl/blinker_pkg.sv
// -----------------------------------------------------------------------------
// blinker_pkg
//   Shared types and helpers for the multi-channel LED blinker.
//   - mode_t    : per-channel mode code (OFF/SLOW/FAST/ON/DIM)
//   - MODE_W    : width of one channel's mode code
//   - cnt_w     : counter width for a counter that holds 0..max_val
//   - next_mode : mode sequence, one step per accepted press
//   Configuration macro: BLINKER_DIM_EN (adds DIM between ON and OFF).
// -----------------------------------------------------------------------------
package blinker_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    OFF  = 3'd0,
    SLOW = 3'd1,
    FAST = 3'd2,
    ON   = 3'd3,
    DIM  = 3'd4
  } mode_t;

  // Width for a counter that must hold 0..max_val. Never below one bit, so
  // degenerate bounds (e.g. a half-period of 1 tick) still give a legal vector.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      OFF:  n = SLOW;
      SLOW: n = FAST;
      FAST: n = ON;
`ifdef BLINKER_DIM_EN
      ON:   n = DIM;
`endif
      default: n = OFF;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/blinker_channel.sv
// -----------------------------------------------------------------------------
// blinker_channel
//   One button/LED channel: 2-flop synchroniser, tick-based debouncer, mode
//   FSM (one step per press) and the LED register with its phase counter.
//   Ports:
//     clk      in  clock
//     rst      in  asynchronous reset, active-high
//     tick     in  one-cycle pulse from the shared prescaler
//     div_cnt  in  prescaler count, used for DIM duty (BLINKER_DIM_EN only)
//     btn      in  raw button level, asynchronous, active-high
//     led      out LED drive, registered
//     mode     out mode code, registered
//   Configuration macro: BLINKER_DIM_EN adds the DIM mode and its duty logic.
// -----------------------------------------------------------------------------
module blinker_channel
  import blinker_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int SLOW_TICKS     = 500,
  parameter int FAST_TICKS     = 125
`ifdef BLINKER_DIM_EN
  ,
  parameter int DIV_W          = 10,
  parameter int DIM_DUTY       = 250
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
`ifdef BLINKER_DIM_EN
  input  logic [DIV_W-1:0]  div_cnt,
`endif
  input  logic              btn,
  output logic              led,
  output logic [MODE_W-1:0] mode
);

  localparam int DEB_W  = cnt_w(DEBOUNCE_TICKS - 1);
  localparam int PH_MAX = ((SLOW_TICKS > FAST_TICKS) ? SLOW_TICKS : FAST_TICKS) - 1;
  localparam int PH_W   = cnt_w(PH_MAX);

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [PH_W-1:0]  SLOW_LAST = PH_W'(SLOW_TICKS - 1);
  localparam logic [PH_W-1:0]  FAST_LAST = PH_W'(FAST_TICKS - 1);

  logic             btn_meta;
  logic             btn_s;
  logic             stable;
  logic [DEB_W-1:0] deb_cnt;
  logic             accept;
  logic             press;
  mode_t            mode_r;
  mode_t            mode_nxt;
  logic [PH_W-1:0]  phase;
  logic [PH_W-1:0]  half_last;
  logic             led_r;

  // Two-flop synchroniser; only btn_s is used downstream.
  // NOTE: every flop is written with <= so all of them sample pre-edge values;
  // blocking assignments here would collapse the two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_s    <= btn_meta;
    end
  end

  // A disagreement must persist for DEBOUNCE_TICKS ticks; the tick on which
  // the count would reach the bound is the one that accepts the new level.
  assign accept = tick && (btn_s != stable) && (deb_cnt == DEB_LAST);

  // Press fires in the cycle whose edge raises stable, so the FSM steps on the
  // same edge as the accepted level and can coincide with a phase wrap.
  assign press = accept && btn_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable  <= 1'b0;
      deb_cnt <= '0;
    end else if (btn_s == stable) begin
      deb_cnt <= '0;
    end else if (tick) begin
      if (deb_cnt == DEB_LAST) begin
        stable  <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign mode_nxt  = next_mode(mode_r);
  assign half_last = (mode_r == SLOW) ? SLOW_LAST : FAST_LAST;

`ifdef BLINKER_DIM_EN
  logic dim_level;
  assign dim_level = (32'(div_cnt) < DIM_DUTY);
`endif

  // Mode FSM with registered LED. A press takes priority over the phase
  // logic, which discards any toggle due on the same tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r <= OFF;
      phase  <= '0;
      led_r  <= 1'b0;
    end else if (press) begin
      mode_r <= mode_nxt;
      phase  <= '0;
      case (mode_nxt)
        SLOW, FAST, ON: led_r <= 1'b1;
`ifdef BLINKER_DIM_EN
        DIM:            led_r <= dim_level;
`endif
        default:        led_r <= 1'b0;
      endcase
    end else begin
      case (mode_r)
        SLOW, FAST: begin
          if (tick) begin
            if (phase == half_last) begin
              phase <= '0;
              led_r <= ~led_r;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        ON:      led_r <= 1'b1;
`ifdef BLINKER_DIM_EN
        DIM:     led_r <= dim_level;
`endif
        default: led_r <= 1'b0;
      endcase
    end
  end

  assign led  = led_r;
  assign mode = mode_r;

endmodule

// File: rtl/blinker_multi.sv
// -----------------------------------------------------------------------------
// blinker_multi
//   N-channel LED blinker: one shared tick prescaler plus CHANNELS independent
//   blinker_channel instances.
//   Ports:
//     system1000      in  clock
//     system1000_rst  in  asynchronous reset, active-high
//     btn_i           in  [CHANNELS]   raw button levels, asynchronous
//     led_o           out [CHANNELS]   LED drive, registered
//     mode_o          out [3*CHANNELS] mode codes, channel k at [3k+2:3k]
//   Configuration macro: BLINKER_DIM_EN enables DIM mode and DIM_DUTY.
// -----------------------------------------------------------------------------
module blinker_multi
  import blinker_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int TICK_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int SLOW_TICKS     = 500,
  parameter int FAST_TICKS     = 125,
  parameter int DIM_DUTY       = 250
) (
  input  logic                         system1000,
  input  logic                         system1000_rst,
  input  logic [CHANNELS-1:0]          btn_i,
  output logic [CHANNELS-1:0]          led_o,
  output logic [MODE_W*CHANNELS-1:0]   mode_o
);

  localparam int DIV_W = cnt_w(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  // Elaboration-time guard on the legal parameter ranges.
  if (CHANNELS < 1 || CHANNELS > 16 || TICK_DIV < 2 || DEBOUNCE_TICKS < 1 ||
      SLOW_TICKS < 1 || FAST_TICKS < 1 || DIM_DUTY < 0 || DIM_DUTY > TICK_DIV)
  begin : g_param_check
    $error("blinker_multi: parameter out of range");
  end

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    blinker_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .SLOW_TICKS     (SLOW_TICKS),
      .FAST_TICKS     (FAST_TICKS)
`ifdef BLINKER_DIM_EN
      ,
      .DIV_W          (DIV_W),
      .DIM_DUTY       (DIM_DUTY)
`endif
    ) u_ch (
      .clk     (system1000),
      .rst     (system1000_rst),
      .tick    (tick),
`ifdef BLINKER_DIM_EN
      .div_cnt (div_cnt),
`endif
      .btn     (btn_i[k]),
      .led     (led_o[k]),
      .mode    (mode_o[MODE_W*k +: MODE_W])
    );
  end

endmodule

// File: tb/tb_blinker_multi.sv
// -----------------------------------------------------------------------------
// tb_blinker_multi
//   Self-checking bench for blinker_multi with small parameters. A behavioural
//   model counts ticks and elapsed cycles to predict every channel's LED and
//   mode; directed steps exercise reset, debounce, collision, mode cycling and
//   channel independence, followed by randomized button activity.
// -----------------------------------------------------------------------------
module tb_blinker_multi;

  localparam int CH   = 2;
  localparam int TD   = 4;
  localparam int DEB  = 2;
  localparam int SLW  = 4;
  localparam int FST  = 1;
  localparam int DUTY = 1;
`ifdef BLINKER_DIM_EN
  localparam int NM = 5;
`else
  localparam int NM = 4;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   btn;
  logic [CH-1:0]   led;
  logic [3*CH-1:0] mode;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  blinker_multi #(
    .CHANNELS       (CH),
    .TICK_DIV       (TD),
    .DEBOUNCE_TICKS (DEB),
    .SLOW_TICKS     (SLW),
    .FAST_TICKS     (FST),
    .DIM_DUTY       (DUTY)
  ) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .btn_i          (btn),
    .led_o          (led),
    .mode_o         (mode)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Per channel: sync history, accepted level, ticks spent disagreeing,
  // mode index, ticks since the current mode was entered, predicted LED.
  int m_div;
  int m_s1[CH], m_s2[CH], m_stable[CH], m_dis[CH];
  int m_mode[CH], m_nt[CH], m_led[CH];

  function automatic void model_reset();
    m_div = 0;
    for (int k = 0; k < CH; k++) begin
      m_s1[k] = 0; m_s2[k] = 0; m_stable[k] = 0; m_dis[k] = 0;
      m_mode[k] = 0; m_nt[k] = 0; m_led[k] = 0;
    end
  endfunction

  function automatic void model_step();
    bit tk;
    tk = (m_div == TD - 1);
    for (int k = 0; k < CH; k++) begin
      bit pr;
      int half;
      pr = 1'b0;
      if (m_s2[k] == m_stable[k]) begin
        m_dis[k] = 0;
      end else if (tk) begin
        m_dis[k]++;
        if (m_dis[k] == DEB) begin
          pr          = (m_s2[k] == 1);
          m_stable[k] = m_s2[k];
          m_dis[k]    = 0;
        end
      end
      if (pr) begin
        m_mode[k] = (m_mode[k] + 1) % NM;
        m_nt[k]   = 0;
        if (m_mode[k] == 4)      m_led[k] = (m_div < DUTY) ? 1 : 0;
        else if (m_mode[k] == 0) m_led[k] = 0;
        else                     m_led[k] = 1;
      end else if (m_mode[k] == 1 || m_mode[k] == 2) begin
        half = (m_mode[k] == 1) ? SLW : FST;
        if (tk) m_nt[k]++;
        m_led[k] = ((m_nt[k] / half) % 2 == 0) ? 1 : 0;
      end else if (m_mode[k] == 3) begin
        m_led[k] = 1;
      end else if (m_mode[k] == 4) begin
        m_led[k] = (m_div < DUTY) ? 1 : 0;
      end else begin
        m_led[k] = 0;
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = int'(btn[k]);
    end
    m_div = (m_div + 1) % TD;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < CH; k++) begin
      check("model_led", 32'(led[k]), 32'(m_led[k]));
      check("model_mode", 32'(mode[3*k +: 3]), 32'(m_mode[k]));
    end
  end

  // Safety net: the sequence below is bounded, this only catches a hang.
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Advance n cycles, landing 2 time units after the rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [CH-1:0] m);
    btn = btn | m;
    cyc(12);
    btn = btn & ~m;
    cyc(12);
  endtask

  initial begin
    int  exp_mode;
    bit  found;
    int  highs;

    rst = 1'b1;
    btn = '0;
    model_reset();
    cyc(3);
    check("reset_led", 32'(led), 32'(0));
    check("reset_mode", 32'(mode), 32'(0));
    rst = 1'b0;
    cyc(5);

    // Debounce: a one-tick pulse must be rejected.
    btn[0] = 1'b1;
    cyc(TD);
    btn[0] = 1'b0;
    cyc(20);
    check("glitch_mode", 32'(mode[2:0]), 32'(0));

    // Debounce: a held level is accepted within the latency bound.
    btn[0] = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 2 + 2 * TD + 1 && !found; i++) begin
      cyc(1);
      if (mode[2:0] == 3'd1) found = 1'b1;
    end
    check("deb_accept", 32'(found), 32'(1));
    check("slow_entry_led", 32'(led[0]), 32'(1));

    // Collision: release now, re-press so acceptance lands 16 cycles after
    // SLOW entry, exactly on the first SLOW phase wrap.
    btn[0] = 1'b0;
    cyc(8);
    btn[0] = 1'b1;
    cyc(7);
    check("slow_hold_led", 32'(led[0]), 32'(1));
    cyc(1);
    check("collision_mode", 32'(mode[2:0]), 32'(2));
    check("collision_led", 32'(led[0]), 32'(1));
    cyc(4);
    check("fast_toggle_low", 32'(led[0]), 32'(0));
    cyc(4);
    check("fast_toggle_high", 32'(led[0]), 32'(1));
    btn[0] = 1'b0;
    cyc(12);

    // Walk the rest of the mode sequence back to OFF.
    exp_mode = 2;
    for (int p = 0; p < NM - 2; p++) begin
      press(2'b01);
      exp_mode = (exp_mode + 1) % NM;
      check("cycle_mode", 32'(mode[2:0]), 32'(exp_mode));
      if (exp_mode == 3) check("on_led", 32'(led[0]), 32'(1));
      if (exp_mode == 4) begin
        highs = 0;
        for (int i = 0; i < 4 * TD; i++) begin
          cyc(1);
          highs += int'(led[0]);
        end
        check("dim_duty", 32'(highs), 32'(4 * DUTY));
      end
    end
    check("off_led", 32'(led[0]), 32'(0));

    // Independence.
    press(2'b11);
    check("both_ch0", 32'(mode[2:0]), 32'(1));
    check("both_ch1", 32'(mode[5:3]), 32'(1));
    press(2'b10);
    check("indep_ch0", 32'(mode[2:0]), 32'(1));
    check("indep_ch1", 32'(mode[5:3]), 32'(2));

    // Randomized button activity; the model checks every cycle.
    for (int i = 0; i < 150; i++) begin
      btn = CH'($urandom_range(0, 3));
      cyc($urandom_range(1, 16));
    end

    // Reset mid-run with both buttons held through it.
    btn = 2'b11;
    cyc(3);
    rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led), 32'(0));
    check("async_rst_mode", 32'(mode), 32'(0));
    cyc(3);
    check("rst_hold_led", 32'(led), 32'(0));
    check("rst_hold_mode", 32'(mode), 32'(0));
    rst = 1'b0;
    cyc(12);
    check("held_rst_ch0", 32'(mode[2:0]), 32'(1));
    check("held_rst_ch1", 32'(mode[5:3]), 32'(1));
    btn = '0;
    cyc(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
